// File: rtl/uart_tx_engine.sv
// uart_tx_engine: parametrised UART transmitter.
// Start bit, DATA_WIDTH data bits sent LSB first, optional parity bit, then one or two stop bits.
// The source hands over a word with a ready/valid handshake. Each frame ends with a one-cycle o_done pulse.
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_parity_enable,
  input  logic                  i_parity_type,
  input  logic                  i_two_stop,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy_flag,
  output logic                  o_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  state_t                  state_q;
  logic [BAUD_W-1:0]       baud_q;
  logic [BIT_W-1:0]        bit_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic                    two_stop_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    ready_q;

  logic                    baud_end;
  logic                    bits_end;
  logic                    accept;

  // Decode the terminal counts and the handshake.
  always_comb begin
    baud_end = (baud_q == BAUD_LAST);
    bits_end = (bit_q == BIT_LAST);
    accept   = i_data_valid & ready_q;
  end

  // Transmit FSM with baud timer, bit counter, shifter and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          bit_q  <= '0;
          if (accept) begin
            // The parity bit is fixed at accept so later config changes cannot affect it.
            shreg_q    <= i_data;
            par_en_q   <= i_parity_enable;
            par_bit_q  <= (^i_data) ^ i_parity_type;
            two_stop_q <= i_two_stop;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= ST_START;
          end else begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end

        ST_START: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= shreg_q[0];
            state_q <= ST_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bits_end) begin
              bit_q <= '0;
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP1;
              end
            end else begin
              // The line is registered, so load the next bit while shifting.
              bit_q   <= bit_q + BIT_W'(1);
              shreg_q <= shreg_q >> 1;
              tx_q    <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        ST_PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        ST_STOP1: begin
          if (baud_end) begin
            baud_q <= '0;
            tx_q   <= 1'b1;
            if (two_stop_q) begin
              state_q <= ST_STOP2;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        ST_STOP2: begin
          if (baud_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        default: begin
          // Recover from an unreachable encoding with the line idle.
          baud_q  <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx        = tx_q;
  assign o_busy_flag = busy_q;
  assign o_done      = done_q;
  assign o_ready     = ready_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine.
// u_dut8 is built with DW=8 and CPB=4. u_dut5 is built with DW=5 and CPB=2.
// Inputs are driven and outputs are checked on the falling clock edge.
module tb_uart_tx_engine;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       valid;
  logic       pe;
  logic       pt;
  logic       ts;
  logic       sel;

  logic ready8, tx8, busy8, done8;
  logic ready5, tx5, busy5, done5;
  logic ready_s, tx_s, busy_s, done_s;

  int tests_run;
  int tests_failed;

  uart_tx_engine #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(valid & ~sel),
    .i_parity_enable(pe), .i_parity_type(pt), .i_two_stop(ts),
    .o_ready(ready8), .o_tx(tx8), .o_busy_flag(busy8), .o_done(done8)
  );

  uart_tx_engine #(.DATA_WIDTH(5), .CLKS_PER_BIT(2)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_data(data[4:0]), .i_data_valid(valid & sel),
    .i_parity_enable(pe), .i_parity_type(pt), .i_two_stop(ts),
    .o_ready(ready5), .o_tx(tx5), .o_busy_flag(busy5), .o_done(done5)
  );

  always_comb begin
    ready_s = sel ? ready5 : ready8;
    tx_s    = sel ? tx5    : tx8;
    busy_s  = sel ? busy5  : busy8;
    done_s  = sel ? done5  : done8;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one falling edge at a time and check that the selected DUT is idle.
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s idle tx %0d", tag, i), 32'(tx_s), 32'd1);
      check($sformatf("%s idle busy %0d", tag, i), 32'(busy_s), 32'd0);
      check($sformatf("%s idle done %0d", tag, i), 32'(done_s), 32'd0);
      check($sformatf("%s idle ready %0d", tag, i), 32'(ready_s), 32'd1);
    end
  endtask

  // Start at a falling edge with the DUT idle, offer one word and check every cycle of the frame.
  // The bits string gives the expected line level per bit period, in transmit order.
  // On return the bench sits at the falling edge of the o_done cycle.
  task automatic send_frame(input string tag, input string bits, input int cpb,
                            input logic [7:0] d, input logic p_en, input logic p_odd,
                            input logic two, input logic hold, input logic disturb);
    int n;
    logic exp_bit;
    n = bits.len() * cpb;
    check({tag, " ready before accept"}, 32'(ready_s), 32'd1);
    data  = d;
    pe    = p_en;
    pt    = p_odd;
    ts    = two;
    valid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      exp_bit = (bits[k / cpb] == "1");
      check($sformatf("%s tx k=%0d", tag, k), 32'(tx_s), 32'(exp_bit));
      check($sformatf("%s busy k=%0d", tag, k), 32'(busy_s), 32'd1);
      check($sformatf("%s ready k=%0d", tag, k), 32'(ready_s), 32'd0);
      check($sformatf("%s done k=%0d", tag, k), 32'(done_s), 32'd0);
      if (k == 0 && !hold) valid = 1'b0;
      if (disturb && k == 12) begin
        data  = ~d;
        pe    = ~p_en;
        pt    = ~p_odd;
        ts    = ~two;
        valid = 1'b1;
      end
      if (disturb && k == 14) valid = 1'b0;
      @(negedge clk);
    end
    check({tag, " done pulse"}, 32'(done_s), 32'd1);
    check({tag, " ready in done"}, 32'(ready_s), 32'd1);
    check({tag, " busy in done"}, 32'(busy_s), 32'd0);
    check({tag, " tx in done"}, 32'(tx_s), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    data  = 8'h00;
    valid = 1'b0;
    pe    = 1'b0;
    pt    = 1'b0;
    ts    = 1'b0;
    sel   = 1'b0;

    // Reset values.
    #1 rst = 1'b1;
    #1;
    check("rst tx8", 32'(tx8), 32'd1);
    check("rst busy8", 32'(busy8), 32'd0);
    check("rst done8", 32'(done8), 32'd0);
    check("rst ready8", 32'(ready8), 32'd1);
    check("rst tx5", 32'(tx5), 32'd1);
    check("rst ready5", 32'(ready5), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle("post_rst", 3);

    // 0xA5, no parity, one stop bit: 10 bits of 4 cycles.
    @(negedge clk);
    send_frame("a5", "0101001011", 4, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("a5", 3);

    // 0x07 with even parity gives a parity bit of 1.
    @(negedge clk);
    send_frame("07even", "01110000011", 4, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("07even", 2);

    // 0x07 with odd parity and two stop bits: parity bit 0, 12 bits, 48 cycles.
    @(negedge clk);
    send_frame("07odd2", "011100000011", 4, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("07odd2", 2);

    // Back to back with valid held: 0x00, then 0xFF accepted in the o_done cycle.
    @(negedge clk);
    send_frame("b2b0", "0000000001", 4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame("b2b1", "0111111111", 4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("b2b", 3);

    // Asynchronous reset during data bit 3 of 0xA5 (cycles 16..19 after accept).
    @(negedge clk);
    data  = 8'hA5;
    pe    = 1'b0;
    ts    = 1'b0;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (17) @(negedge clk);
    check("abort tx before rst", 32'(tx8), 32'd0);
    check("abort busy before rst", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort tx async", 32'(tx8), 32'd1);
    check("abort busy async", 32'(busy8), 32'd0);
    check("abort ready async", 32'(ready8), 32'd1);
    check("abort done async", 32'(done8), 32'd0);
    @(negedge clk);
    check("abort done in rst", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle("abort", 12);
    @(negedge clk);
    send_frame("after_abort", "0101001011", 4, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("after_abort", 2);

    // Config, data and valid change mid-frame. Only the values latched at accept are used.
    @(negedge clk);
    send_frame("disturb", "0111000001", 4, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("disturb", 45);

    // DW=5, CPB=2, odd parity, 5'h1F: 8 bits over 16 cycles.
    sel = 1'b1;
    @(negedge clk);
    send_frame("dw5", "01111101", 2, 8'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("dw5", 3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
